// File: rtl/xorshift_checker.sv
// xorshift_checker
//   Tracks an observed xorshift128 output stream. Four valid samples seed an
//   internal X,Y,Z,W model (acquire); afterwards every valid sample is
//   compared with the model's prediction. Mismatches raise a one-cycle err
//   pulse, bump a saturating counter, and the model advances on its own
//   prediction (flywheel) so that a single corrupted word does not desync it.
//
//   Optional feature: define XORSHIFT_CHK_RESYNC_EN to drop back to acquire
//   after LOSS_THRESH consecutive mismatches. Without it, lock is sticky.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   qualifies in_data
//   in_data    observed generator word
//   locked     model is tracking the stream (registered)
//   err        one-cycle pulse after a mismatched sample (registered)
//   err_count  saturating mismatch total since reset (registered)
//   expected   predicted next word while locked, else 0
module xorshift_checker #(
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count,
  output logic [31:0] expected
);

  localparam logic [4:0] THRESH = 5'(LOSS_THRESH);

  typedef enum logic {ACQ, LOCK} state_t;

  state_t      state, state_nxt;
  logic [31:0] x, y, z, w;
  logic [31:0] t, p;
  logic [1:0]  acq_cnt, acq_nxt;
  logic [3:0]  miss, miss_nxt;
  logic [4:0]  miss_inc;
  logic        err_nxt;
  logic [15:0] err_count_nxt;
  logic        shift;
  logic [31:0] shift_word;

  // Prediction of the next generator word from the model state.
  always_comb begin
    t = x ^ (x << 11);
    p = (w ^ (w >> 19)) ^ t ^ (t >> 8);
  end

  assign miss_inc = {1'b0, miss} + 5'd1;
  assign expected = locked ? p : '0;

  always_comb begin
    state_nxt     = state;
    acq_nxt       = acq_cnt;
    miss_nxt      = miss;
    err_nxt       = 1'b0;
    err_count_nxt = err_count;
    shift         = 1'b0;
    shift_word    = in_data;
    if (in_valid) begin
      unique case (state)
        ACQ: begin
          shift   = 1'b1;
          acq_nxt = acq_cnt + 2'd1;
          if (acq_cnt == 2'd3) state_nxt = LOCK;
        end
        LOCK: begin
          shift = 1'b1;
          if (in_data == p) begin
            miss_nxt = '0;
          end else begin
            // Flywheel: advance on our own prediction, not the bad word.
            shift_word = p;
            err_nxt    = 1'b1;
            if (err_count != '1) err_count_nxt = err_count + 16'd1;
            if (miss_inc >= THRESH) begin
`ifdef XORSHIFT_CHK_RESYNC_EN
              state_nxt = ACQ;
              acq_nxt   = '0;
              miss_nxt  = '0;
`else
              miss_nxt  = THRESH[3:0];
`endif
            end else begin
              miss_nxt = miss_inc[3:0];
            end
          end
        end
        default: state_nxt = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACQ;
      acq_cnt   <= '0;
      miss      <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      w         <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      acq_cnt   <= acq_nxt;
      miss      <= miss_nxt;
      locked    <= (state_nxt == LOCK);
      err       <= err_nxt;
      err_count <= err_count_nxt;
      if (shift) begin
        x <= y;
        y <= z;
        z <= w;
        w <= shift_word;
      end
    end
  end

endmodule
